// File: rtl/fuzz_equiv_sequencer.sv
// fuzz_equiv_sequencer
//
// Steps a stream of stimulus vectors through two implementations of one design
// (A: behavioural, B: synthesised netlist). Each accepted vector is registered
// onto dut_in. After LAT settle cycles, y_a and y_b are compared bit for bit.
// Mismatches are counted, the index of the first one is kept, and the run ends
// on the vector flagged last, or at the first mismatch when stop_on_fail is set.
//
// Optional feature: define FUZZ_EQUIV_SIG_EN to build a 32-bit rolling
// signature over y_a. Without it, sig is tied to zero and no fold logic exists.
//
// Ports:
//   clk, rst        clock (rising edge), synchronous active-high reset
//   start           one-cycle pulse; begins a run from IDLE or DONE
//   stop_on_fail    end the run at the first mismatching compare
//   vec_valid       stimulus source offers vec_data
//   vec_last        marks the final vector of the run
//   vec_data        stimulus vector (IN_W bits)
//   vec_ready       sequencer accepts a vector (FETCH only)
//   dut_in          registered stimulus driven to both DUTs
//   y_a, y_b        results of DUT A and DUT B (OUT_W bits)
//   busy            run in progress
//   done            run finished; held until the next start
//   pass            with done: no mismatch seen
//   vec_cnt         vectors applied (saturating)
//   fail_cnt        mismatching compares (saturating)
//   first_fail_idx  zero-based index of the first mismatching vector
//   sig             result signature, or 0 when the feature is not built
module fuzz_equiv_sequencer #(
    parameter int unsigned IN_W  = 64,
    parameter int unsigned OUT_W = 199,
    parameter int unsigned LAT   = 1,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop_on_fail,
    input  logic             vec_valid,
    input  logic             vec_last,
    input  logic [IN_W-1:0]  vec_data,
    output logic             vec_ready,
    output logic [IN_W-1:0]  dut_in,
    input  logic [OUT_W-1:0] y_a,
    input  logic [OUT_W-1:0] y_b,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] vec_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [CNT_W-1:0] first_fail_idx,
    output logic [31:0]      sig
);

    // Last SETTLE count value; unused when LAT is 0 (FETCH goes straight to COMPARE).
    localparam logic [3:0] LatM1 = (LAT == 0) ? 4'd0 : 4'(LAT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StSettle,
        StCompare,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [3:0]        settle_q, settle_d;
    logic [IN_W-1:0]   dut_in_q, dut_in_d;
    logic [CNT_W-1:0]  vec_cnt_q, vec_cnt_d;
    logic [CNT_W-1:0]  fail_cnt_q, fail_cnt_d;
    logic [CNT_W-1:0]  first_q, first_d;
    logic              last_q, last_d;

    logic              start_ok;
    logic              mismatch;

    assign start_ok = start && ((state_q == StIdle) || (state_q == StDone));
    assign mismatch = (y_a != y_b);

    always_comb begin
        state_d    = state_q;
        settle_d   = settle_q;
        dut_in_d   = dut_in_q;
        vec_cnt_d  = vec_cnt_q;
        fail_cnt_d = fail_cnt_q;
        first_d    = first_q;
        last_d     = last_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    vec_cnt_d  = '0;
                    fail_cnt_d = '0;
                    first_d    = '0;
                    state_d    = StFetch;
                end
            end
            StFetch: begin
                if (vec_valid) begin
                    dut_in_d = vec_data;
                    if (vec_cnt_q != '1) begin
                        vec_cnt_d = vec_cnt_q + 1'b1;
                    end
                    last_d   = vec_last;
                    settle_d = '0;
                    state_d  = (LAT == 0) ? StCompare : StSettle;
                end
            end
            StSettle: begin
                if (settle_q == LatM1) begin
                    state_d = StCompare;
                end else begin
                    settle_d = settle_q + 4'd1;
                end
            end
            StCompare: begin
                if (mismatch) begin
                    if (fail_cnt_q != '1) begin
                        fail_cnt_d = fail_cnt_q + 1'b1;
                    end
                    // fail_cnt is cleared at start and never wraps, so zero means
                    // this is the first mismatch of the run.
                    if (fail_cnt_q == '0) begin
                        first_d = vec_cnt_q - 1'b1;
                    end
                end
                if (last_q || (stop_on_fail && mismatch)) begin
                    state_d = StDone;
                end else begin
                    state_d = StFetch;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            settle_q   <= '0;
            dut_in_q   <= '0;
            vec_cnt_q  <= '0;
            fail_cnt_q <= '0;
            first_q    <= '0;
            last_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            settle_q   <= settle_d;
            dut_in_q   <= dut_in_d;
            vec_cnt_q  <= vec_cnt_d;
            fail_cnt_q <= fail_cnt_d;
            first_q    <= first_d;
            last_q     <= last_d;
        end
    end

`ifdef FUZZ_EQUIV_SIG_EN
    localparam int unsigned SigSlices = (OUT_W + 31) / 32;

    // XOR of consecutive 32-bit slices, top slice zero-padded.
    function automatic logic [31:0] fold32(input logic [OUT_W-1:0] v);
        logic [SigSlices*32-1:0] padded;
        logic [31:0]             acc;
        padded            = '0;
        padded[OUT_W-1:0] = v;
        acc               = '0;
        for (int i = 0; i < SigSlices; i++) begin
            acc = acc ^ padded[i*32 +: 32];
        end
        return acc;
    endfunction

    logic [31:0] sig_q, sig_d;

    always_comb begin
        sig_d = sig_q;
        if (start_ok) begin
            sig_d = '0;
        end else if (state_q == StCompare) begin
            sig_d = {sig_q[30:0], sig_q[31]} ^ fold32(y_a);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;
`else
    assign sig = '0;
`endif

    assign vec_ready      = (state_q == StFetch);
    assign busy           = (state_q == StFetch) || (state_q == StSettle) ||
                            (state_q == StCompare);
    assign done           = (state_q == StDone);
    assign pass           = done && (fail_cnt_q == '0);
    assign dut_in         = dut_in_q;
    assign vec_cnt        = vec_cnt_q;
    assign fail_cnt       = fail_cnt_q;
    assign first_fail_idx = first_q;

endmodule

// File: tb/tb_fuzz_equiv_sequencer.sv
// Bench for fuzz_equiv_sequencer: one instance with LAT=1 and one with LAT=0,
// sharing stimulus; sel picks whose outputs are observed and drive y_a/y_b.
module tb_fuzz_equiv_sequencer;

    localparam int unsigned IN_W  = 64;
    localparam int unsigned OUT_W = 199;
    localparam int unsigned CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             stop_on_fail = 1'b0;
    logic             vec_valid = 1'b0;
    logic             vec_last = 1'b0;
    logic [IN_W-1:0]  vec_data = '0;
    logic [OUT_W-1:0] y_a, y_b;

    logic             r0, r1, b0, b1, d0, d1, p0, p1;
    logic [IN_W-1:0]  di0, di1;
    logic [CNT_W-1:0] vc0, vc1, fc0, fc1, ff0, ff1;
    logic [31:0]      sg0, sg1;

    bit               sel = 1'b0;
    bit               ya_one = 1'b0;
    logic [31:0]      bad_data = '0;   // bit k set: vector with data k mismatches

    logic             m_ready, m_busy, m_done, m_pass;
    logic [IN_W-1:0]  m_dut_in;
    logic [CNT_W-1:0] m_vec, m_fail, m_first;
    logic [31:0]      m_sig;
    int               m_lat;
    logic [4*IN_W-1:0] rep;

    assign m_ready  = sel ? r1  : r0;
    assign m_busy   = sel ? b1  : b0;
    assign m_done   = sel ? d1  : d0;
    assign m_pass   = sel ? p1  : p0;
    assign m_dut_in = sel ? di1 : di0;
    assign m_vec    = sel ? vc1 : vc0;
    assign m_fail   = sel ? fc1 : fc0;
    assign m_first  = sel ? ff1 : ff0;
    assign m_sig    = sel ? sg1 : sg0;
    assign m_lat    = sel ? 0 : 1;

    assign rep = {4{m_dut_in}};
    assign y_a = ya_one ? OUT_W'(1) : rep[OUT_W-1:0];
    assign y_b = y_a ^ (bad_data[m_dut_in[4:0]] ? (OUT_W'(1) << (OUT_W - 1)) : '0);

    fuzz_equiv_sequencer #(.IN_W(IN_W), .OUT_W(OUT_W), .LAT(1), .CNT_W(CNT_W)) u_dut_lat1 (
        .clk(clk), .rst(rst), .start(start), .stop_on_fail(stop_on_fail),
        .vec_valid(vec_valid), .vec_last(vec_last), .vec_data(vec_data),
        .vec_ready(r0), .dut_in(di0), .y_a(y_a), .y_b(y_b),
        .busy(b0), .done(d0), .pass(p0), .vec_cnt(vc0), .fail_cnt(fc0),
        .first_fail_idx(ff0), .sig(sg0)
    );

    fuzz_equiv_sequencer #(.IN_W(IN_W), .OUT_W(OUT_W), .LAT(0), .CNT_W(CNT_W)) u_dut_lat0 (
        .clk(clk), .rst(rst), .start(start), .stop_on_fail(stop_on_fail),
        .vec_valid(vec_valid), .vec_last(vec_last), .vec_data(vec_data),
        .vec_ready(r1), .dut_in(di1), .y_a(y_a), .y_b(y_b),
        .busy(b1), .done(d1), .pass(p1), .vec_cnt(vc1), .fail_cnt(fc1),
        .first_fail_idx(ff1), .sig(sg1)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: transfers push what must appear on dut_in and what the compare
    // of that vector must produce; the monitor pops after the DUT acts on it.
    typedef struct {
        logic [IN_W-1:0] data;
        bit              mism;
        bit              last;
    } item_t;

    item_t sb[$];
    item_t cur;
    int    since = -1;
    int    exp_vec = 0;
    int    exp_fail = 0;
    int    exp_first = 0;
    bit    seen = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            since = -1;
        end else begin
            if (start && !m_busy) begin
                exp_vec = 0; exp_fail = 0; exp_first = 0; seen = 1'b0;
            end
            if (since >= 0) since++;
            if (since == 1) begin
                if (sb.size() == 0) begin
                    chk("sb_empty", 256'(1), 256'(0));
                end else begin
                    cur = sb.pop_front();
                    chk("sb_dut_in", 256'(m_dut_in), 256'(cur.data));
                    chk("sb_vec_cnt", 256'(m_vec), 256'(exp_vec));
                end
            end
            if (since == m_lat + 1) begin
                chk("cmp_cycle_ready", 256'(m_ready), 256'(0));
                chk("cmp_cycle_busy", 256'(m_busy), 256'(1));
            end
            if (since == m_lat + 2) begin
                if (cur.mism) begin
                    exp_fail++;
                    if (!seen) begin
                        seen = 1'b1;
                        exp_first = exp_vec - 1;
                    end
                end
                chk("sb_fail_cnt", 256'(m_fail), 256'(exp_fail));
                chk("sb_first_idx", 256'(m_first), 256'(exp_first));
                chk("sb_done", 256'(m_done), 256'(cur.last || (stop_on_fail && cur.mism)));
                since = -1;
            end
            if (vec_valid && m_ready) begin
                exp_vec++;
                sb.push_back('{data: vec_data, mism: bad_data[vec_data[4:0]], last: vec_last});
                since = 0;
            end
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_dut_in"}, 256'(m_dut_in), 256'(0));
        chk({tag, "_ready"}, 256'(m_ready), 256'(0));
        chk({tag, "_busy"}, 256'(m_busy), 256'(0));
        chk({tag, "_done"}, 256'(m_done), 256'(0));
        chk({tag, "_pass"}, 256'(m_pass), 256'(0));
        chk({tag, "_vec_cnt"}, 256'(m_vec), 256'(0));
        chk({tag, "_fail_cnt"}, 256'(m_fail), 256'(0));
        chk({tag, "_first"}, 256'(m_first), 256'(0));
        chk({tag, "_sig"}, 256'(m_sig), 256'(0));
    endtask

    task automatic do_reset(input bit check);
        vec_valid = 1'b0; vec_last = 1'b0; start = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        if (check) check_all_zero("reset");
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Offers vectors with data i+1 until n transfers happen or the run ends.
    // Returns in the cycle after the last transfer.
    task automatic drive_vectors(input int n, input bit tog, input bit last_on);
        int  i = 0;
        int  cyc = 0;
        bit  ph = 1'b0;
        bit  xfer;
        while (i < n && cyc < 400 && !m_done) begin
            ph        = ~ph;
            vec_valid = tog ? ph : 1'b1;
            vec_data  = IN_W'(i + 1);
            vec_last  = last_on && (i == n - 1);
            xfer      = vec_valid && m_ready;
            @(posedge clk); #1;
            if (xfer) i++;
            cyc++;
        end
        vec_valid = 1'b0;
        vec_last  = 1'b0;
        if (cyc >= 400) chk("drive_timeout", 256'(i), 256'(n));
    endtask

    task automatic wait_done();
        int k = 0;
        while (!m_done && k < 60) begin
            @(posedge clk); #1;
            k++;
        end
        chk("wait_done", 256'(m_done), 256'(1));
    endtask

    typedef struct {
        bit          sel;
        int          n;
        logic [31:0] bad;
        bit          sof;
        bit          tog;
        int          e_vec;
        int          e_fail;
        int          e_first;
        bit          e_pass;
    } case_t;

    case_t tbl[6];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // sel n  bad        sof tog  vec fail first pass
        tbl[0] = '{1'b0, 3,  32'h0,     1'b0, 1'b0, 3,  0, 0, 1'b1};
        tbl[1] = '{1'b0, 5,  32'h14,    1'b0, 1'b0, 5,  2, 1, 1'b0};
        tbl[2] = '{1'b0, 10, 32'h8,     1'b1, 1'b0, 3,  1, 2, 1'b0};
        tbl[3] = '{1'b1, 3,  32'h0,     1'b0, 1'b1, 3,  0, 0, 1'b1};
        tbl[4] = '{1'b1, 4,  32'h2,     1'b1, 1'b1, 1,  1, 0, 1'b0};
        tbl[5] = '{1'b0, 6,  32'h3E,    1'b0, 1'b0, 6,  5, 0, 1'b0};

        do_reset(1'b1);

        for (int c = 0; c < 6; c++) begin
            sel          = tbl[c].sel;
            bad_data     = tbl[c].bad;
            stop_on_fail = tbl[c].sof;
            ya_one       = 1'b0;
            do_reset(1'b0);
            pulse_start();
            chk("start_busy", 256'(m_busy), 256'(1));
            drive_vectors(tbl[c].n, tbl[c].tog, 1'b1);
            wait_done();
            chk("end_vec_cnt", 256'(m_vec), 256'(tbl[c].e_vec));
            chk("end_fail_cnt", 256'(m_fail), 256'(tbl[c].e_fail));
            chk("end_first_idx", 256'(m_first), 256'(tbl[c].e_first));
            chk("end_pass", 256'(m_pass), 256'(tbl[c].e_pass));
            chk("end_busy", 256'(m_busy), 256'(0));
            // Source keeps offering; nothing must be accepted after DONE.
            vec_valid = 1'b1;
            repeat (3) @(posedge clk);
            #1;
            chk("hold_ready", 256'(m_ready), 256'(0));
            chk("hold_done", 256'(m_done), 256'(1));
            chk("hold_vec_cnt", 256'(m_vec), 256'(tbl[c].e_vec));
            vec_valid = 1'b0;
        end

        // Reset during SETTLE of the fourth vector, then a clean restart.
        sel = 1'b0; bad_data = 32'h0; stop_on_fail = 1'b0; ya_one = 1'b0;
        do_reset(1'b0);
        pulse_start();
        drive_vectors(4, 1'b0, 1'b0);
        chk("mid_in_settle", 256'({m_ready, m_busy}), 256'(2'b01));
        rst = 1'b1;
        @(posedge clk); #1;
        check_all_zero("midrst");
        rst = 1'b0;
        @(posedge clk); #1;
        chk("midrst_idle", 256'({m_busy, m_done}), 256'(0));
        pulse_start();
        chk("restart_vec_cnt", 256'(m_vec), 256'(0));
        chk("restart_ready", 256'(m_ready), 256'(1));
        drive_vectors(2, 1'b0, 1'b1);
        wait_done();
        chk("restart_end_vec", 256'(m_vec), 256'(2));
        chk("restart_pass", 256'(m_pass), 256'(1));

        // Signature with y_a=1 over two compares; a start while busy is ignored.
        sel = 1'b0; ya_one = 1'b1; bad_data = 32'h0;
        do_reset(1'b0);
        pulse_start();
        drive_vectors(1, 1'b0, 1'b0);
        pulse_start();
        drive_vectors(1, 1'b0, 1'b1);
        wait_done();
        chk("sig_vec_cnt", 256'(m_vec), 256'(2));
`ifdef FUZZ_EQUIV_SIG_EN
        chk("sig_value", 256'(m_sig), 256'(32'h0000_0003));
`else
        chk("sig_value", 256'(m_sig), 256'(0));
`endif
        // A new start from DONE clears the signature and counters.
        pulse_start();
        chk("restart_sig", 256'(m_sig), 256'(0));
        chk("restart_done", 256'(m_done), 256'(0));
        ya_one = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
